// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter - shares the single processor-memory port between icache and dcache
// with a retry lock for rejected requests and a starvation bound on icache wait.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3,
  parameter int ADDR_W       = 32,
  parameter int BLOCK_W      = 64,
  parameter int TAG_W        = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         icache_command,
  input  logic [ADDR_W-1:0]  icache_addr,
  input  logic [1:0]         dcache_command,
  input  logic [ADDR_W-1:0]  dcache_addr,
  input  logic [BLOCK_W-1:0] dcache_data,
  input  logic [TAG_W-1:0]   mem_transaction_tag,
  output logic [1:0]         proc2mem_command,
  output logic [ADDR_W-1:0]  proc2mem_addr,
  output logic [BLOCK_W-1:0] proc2mem_data,
  output logic [TAG_W-1:0]   icache_transaction_tag,
  output logic [TAG_W-1:0]   dcache_transaction_tag,
  output logic               dcache_request,
  output logic               grant_icache,
  output logic               grant_dcache
);

  localparam logic [1:0] MEM_NONE  = 2'd0;
  localparam logic [1:0] MEM_STORE = 2'd2;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] starve_cnt, starve_next;
  logic             icache_req, dcache_req;
  logic             sel_icache, sel_dcache;
  logic             accepted;

  assign icache_req     = (icache_command != MEM_NONE);
  assign dcache_req     = (dcache_command != MEM_NONE);
  assign dcache_request = dcache_req;
  assign accepted       = (mem_transaction_tag != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FREE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
    end
  end

  // A live lock wins outright; a withdrawn lock falls through to free arbitration.
  always_comb begin
    sel_icache = 1'b0;
    sel_dcache = 1'b0;
    if (state == LOCK_I && icache_req) begin
      sel_icache = 1'b1;
    end else if (state == LOCK_D && dcache_req) begin
      sel_dcache = 1'b1;
    end else if (icache_req && dcache_req) begin
      if (starve_cnt == LIMIT) sel_icache = 1'b1;
      else                     sel_dcache = 1'b1;
    end else if (icache_req) begin
      sel_icache = 1'b1;
    end else if (dcache_req) begin
      sel_dcache = 1'b1;
    end
  end

  always_comb begin
    proc2mem_command       = MEM_NONE;
    proc2mem_addr          = '0;
    proc2mem_data          = '0;
    icache_transaction_tag = '0;
    dcache_transaction_tag = '0;
    grant_icache           = 1'b0;
    grant_dcache           = 1'b0;
    state_next             = FREE;
    starve_next            = starve_cnt;

    if (!reset) begin
      if (sel_icache) begin
        grant_icache           = 1'b1;
        proc2mem_command       = icache_command;
        proc2mem_addr          = icache_addr;
        icache_transaction_tag = mem_transaction_tag;
        state_next             = accepted ? FREE : LOCK_I;
      end else if (sel_dcache) begin
        grant_dcache           = 1'b1;
        proc2mem_command       = dcache_command;
        proc2mem_addr          = dcache_addr;
        proc2mem_data          = (dcache_command == MEM_STORE) ? dcache_data : '0;
        dcache_transaction_tag = mem_transaction_tag;
        state_next             = accepted ? FREE : LOCK_D;
      end
    end

    // A rejected icache grant keeps its count so it retains priority after the retry.
    if (!icache_req) begin
      starve_next = '0;
    end else if (sel_icache && accepted) begin
      starve_next = '0;
    end else if (sel_dcache && starve_cnt != LIMIT) begin
      starve_next = starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter - directed and random checks of mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  icache_command, dcache_command;
  logic [31:0] icache_addr, dcache_addr;
  logic [63:0] dcache_data;
  logic [3:0]  mem_transaction_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  icache_transaction_tag, dcache_transaction_tag;
  logic        dcache_request, grant_icache, grant_dcache;

  int tests = 0;
  int fails = 0;

  // Model: who holds the lock (0 none, 1 icache, 2 dcache) and how long icache has waited.
  int lock_owner = 0;
  int waited = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clock(clock), .reset(reset),
    .icache_command(icache_command), .icache_addr(icache_addr),
    .dcache_command(dcache_command), .dcache_addr(dcache_addr),
    .dcache_data(dcache_data), .mem_transaction_tag(mem_transaction_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .icache_transaction_tag(icache_transaction_tag),
    .dcache_transaction_tag(dcache_transaction_tag),
    .dcache_request(dcache_request),
    .grant_icache(grant_icache), .grant_dcache(grant_dcache)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check every output against the model, then advance the model.
  task automatic step(input string name, input logic rst,
                      input logic [1:0] ic, input logic [31:0] ia,
                      input logic [1:0] dc, input logic [31:0] da,
                      input logic [63:0] dd, input logic [3:0] tg);
    int winner;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    reset = rst; icache_command = ic; icache_addr = ia;
    dcache_command = dc; dcache_addr = da; dcache_data = dd; mem_transaction_tag = tg;

    winner = 0;
    if (lock_owner == 1 && ic != NONE)      winner = 1;
    else if (lock_owner == 2 && dc != NONE) winner = 2;
    else if (ic != NONE && dc != NONE)      winner = (waited >= LIMIT) ? 1 : 2;
    else if (ic != NONE)                    winner = 1;
    else if (dc != NONE)                    winner = 2;
    if (rst) winner = 0;

    e_cmd  = (winner == 1) ? ic : (winner == 2) ? dc : NONE;
    e_addr = (winner == 1) ? ia : (winner == 2) ? da : 32'h0;
    e_data = (winner == 2 && dc == STORE) ? dd : 64'h0;

    #2;
    chk({name, ".grant_i"}, 64'(grant_icache), 64'(winner == 1));
    chk({name, ".grant_d"}, 64'(grant_dcache), 64'(winner == 2));
    chk({name, ".cmd"},     64'(proc2mem_command), 64'(e_cmd));
    chk({name, ".addr"},    64'(proc2mem_addr), 64'(e_addr));
    chk({name, ".data"},    proc2mem_data, e_data);
    chk({name, ".itag"},    64'(icache_transaction_tag), 64'((winner == 1) ? tg : 4'h0));
    chk({name, ".dtag"},    64'(dcache_transaction_tag), 64'((winner == 2) ? tg : 4'h0));
    chk({name, ".dreq"},    64'(dcache_request), 64'(dc != NONE));

    @(posedge clock);
    if (rst) begin
      lock_owner = 0;
      waited = 0;
    end else begin
      lock_owner = (winner != 0 && tg == 4'h0) ? winner : 0;
      if (ic == NONE || (winner == 1 && tg != 4'h0)) waited = 0;
      else if (winner == 2 && waited < LIMIT)        waited = waited + 1;
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; icache_command = NONE; dcache_command = NONE;
    icache_addr = '0; dcache_addr = '0; dcache_data = '0; mem_transaction_tag = '0;
    @(posedge clock); #1;
    step("reset", 1'b1, LOAD, 32'h40, LOAD, 32'h80, 64'h0, 4'd1);

    // 1: lone icache load
    step("t1", 1'b0, LOAD, 32'h100, NONE, 32'h0, 64'h0, 4'd3);
    // 2-3: continuous contention, dcache wins LIMIT times then icache once
    for (int i = 0; i < LIMIT + 2; i++)
      step("t3", 1'b0, LOAD, 32'h140, LOAD, 32'h180, 64'h0, 4'd5);
    // 4: dcache store rejected twice then accepted, icache contending
    for (int i = 0; i < 3; i++)
      step("t4", 1'b0, LOAD, 32'h1C0, STORE, 32'h200, 64'hDEAD, (i == 2) ? 4'd7 : 4'd0);
    step("t4f", 1'b0, NONE, 32'h0, STORE, 32'h240, 64'hBEEF, 4'd2);
    // 5: icache locked, then withdraws while dcache requests
    step("t5a", 1'b0, LOAD, 32'h300, NONE, 32'h0, 64'h0, 4'd0);
    step("t5b", 1'b0, NONE, 32'h300, LOAD, 32'h340, 64'h0, 4'd4);
    step("t5c", 1'b0, LOAD, 32'h300, LOAD, 32'h340, 64'h0, 4'd4);
    // 6: build starve=3 with LOCK_D, reset mid-lock, then confirm counter restarted
    step("t6a", 1'b0, LOAD, 32'h400, LOAD, 32'h440, 64'h0, 4'd1);
    step("t6b", 1'b0, LOAD, 32'h400, LOAD, 32'h440, 64'h0, 4'd0);
    step("t6r", 1'b1, LOAD, 32'h400, STORE, 32'h440, 64'h55, 4'd6);
    for (int i = 0; i < LIMIT + 1; i++)
      step("t6n", 1'b0, LOAD, 32'h400, LOAD, 32'h480, 64'h0, 4'd2);

    for (int i = 0; i < 400; i++) begin
      logic [1:0] ic, dc;
      ic = ($urandom_range(0, 3) == 0) ? NONE : LOAD;
      dc = 2'($urandom_range(0, 2));
      step("rnd", ($urandom_range(0, 49) == 0), ic, $urandom, dc, $urandom,
           {$urandom, $urandom}, ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
